// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
// Holds the queue entry layout, the fetch state encoding and the PC legality check.
package fetch_pkg;

   localparam int unsigned WORD_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_e;

   // The +3 is done in 33 bits so a PC near 2^32 cannot wrap into range.
   function automatic logic pc_is_bad(input logic [31:0] pc, input int unsigned mem_bytes);
      logic [32:0] w_last_byte;
      w_last_byte = {1'b0, pc} + 33'd3;
      return (pc[1:0] != 2'b00) || (w_last_byte >= 33'(mem_bytes));
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of {pc, instr} entries with a flush that beats push.
// Pointers carry one extra wrap bit so full and empty need no separate counter.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wdata,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign head  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // Storage is never reset; the pointers alone decide what is visible.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         r_mem[r_wr_ptr[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the fetch PC, drives the combinational ROM and
// feeds decode through a prefetch queue. Optional counters under FETCH_PERF_EN.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned DEPTH     = 2
)
(
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        fault,
   output logic [31:0] fault_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls,
   output logic [15:0] perf_flushes
`endif
);

   fetch_state_e r_state;
   fetch_state_e w_next_state;
   logic [31:0]  r_fetch_pc;
   logic [31:0]  r_fault_pc;
   logic [31:0]  r_last_addr;
   logic [31:0]  w_imem_addr;
   logic         w_pc_bad;
   logic         w_push;
   logic         w_pop;
   logic         w_full;
   logic         w_empty;
   fetch_entry_t w_head;
   fetch_entry_t w_wdata;

   assign w_pc_bad = pc_is_bad(r_fetch_pc, MEM_BYTES);
   assign w_pop    = !w_empty && out_ready;
   assign w_wdata  = '{pc: r_fetch_pc, instr: imem_instr};

   // The ROM only ever sees a PC that passed the bound check.
   assign w_imem_addr = (r_state == RUN && !w_pc_bad) ? r_fetch_pc : r_last_addr;
   assign imem_addr   = w_imem_addr;

   always_comb begin
      w_next_state = r_state;
      w_push       = 1'b0;
      if (redirect_valid) begin
         w_next_state = RUN;
      end else if (r_state == RUN) begin
         if (w_pc_bad) begin
            w_next_state = FAULT;
         end else if (!w_full || w_pop) begin
            w_push = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc  <= RESET_PC;
         r_fault_pc  <= '0;
         r_last_addr <= '0;
      end else begin
         r_last_addr <= w_imem_addr;
         if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_fault_pc <= '0;
         end else begin
            if (w_push) begin
               r_fetch_pc <= r_fetch_pc + 32'(WORD_BYTES);
            end
            if (r_state == RUN && w_pc_bad) begin
               r_fault_pc <= r_fetch_pc;
            end
         end
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .flush (redirect_valid),
      .wdata (w_wdata),
      .full  (w_full),
      .empty (w_empty),
      .head  (w_head)
   );

   // An empty queue presents zeros rather than stale storage.
   assign out_valid = !w_empty;
   assign out_pc    = w_empty ? 32'h0 : w_head.pc;
   assign out_instr = w_empty ? 32'h0 : w_head.instr;
   assign fault     = (r_state == FAULT);
   assign fault_pc  = r_fault_pc;

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_stalls;
   logic [15:0] r_perf_flushes;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_fetched <= '0;
         r_perf_stalls  <= '0;
         r_perf_flushes <= '0;
      end else begin
         if (w_push) begin
            r_perf_fetched <= r_perf_fetched + 32'd1;
         end
         if (r_state == RUN && w_full && !w_pop) begin
            r_perf_stalls <= r_perf_stalls + 32'd1;
         end
         if (redirect_valid) begin
            r_perf_flushes <= r_perf_flushes + 16'd1;
         end
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_stalls  = r_perf_stalls;
   assign perf_flushes = r_perf_flushes;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table followed by a randomized run
// against a queue-based reference model, with the ROM image word n = A000_0000+n.
module tb_fetch_sequencer;

   localparam logic [31:0] RESET_PC  = 32'h0;
   localparam int unsigned MEM_BYTES = 1024;
   localparam int unsigned DEPTH     = 2;

   logic        clk;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        fault;
   logic [31:0] fault_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stalls;
   logic [15:0] perf_flushes;
`endif

   int n_checks = 0;
   int n_errors = 0;

   fetch_sequencer #(
      .RESET_PC  (RESET_PC),
      .MEM_BYTES (MEM_BYTES),
      .DEPTH     (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .fault          (fault),
      .fault_pc       (fault_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stalls    (perf_stalls),
      .perf_flushes   (perf_flushes)
`endif
   );

   // ROM model
   assign imem_instr = 32'hA000_0000 + (imem_addr >> 2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Directed vectors: inputs for a cycle and the outputs expected in that cycle.
   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] einstr;
      logic        ef;
      logic [31:0] efpc;
      logic [31:0] eaddr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                      input logic ev, input logic [31:0] epc, input logic [31:0] einstr,
                      input logic ef, input logic [31:0] efpc, input logic [31:0] eaddr);
      vec_t v;
      v = '{rst, rv, rpc, rdy, ev, epc, einstr, ef, efpc, eaddr};
      vecs.push_back(v);
   endtask

   // Reference model: an abstract queue plus fetch PC and fault flag.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   logic [31:0] m_fpc;
   logic [31:0] m_last;
   bit          m_fault;

   function automatic bit m_bad(input logic [31:0] pc);
      return (pc % 4 != 0) || (({32'h0, pc} + 64'd3) >= 64'(MEM_BYTES));
   endfunction

   function automatic logic [31:0] m_addr();
      return (!m_fault && !m_bad(m_pc)) ? m_pc : m_last;
   endfunction

   task automatic m_step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
      ent_t        e;
      bit          pop;
      logic [31:0] a;
      a = m_addr();
      if (rst) begin
         mq.delete();
         m_pc    = RESET_PC;
         m_fault = 0;
         m_fpc   = 0;
         m_last  = 0;
      end else begin
         pop    = (mq.size() > 0) && rdy;
         m_last = a;
         if (rv) begin
            mq.delete();
            m_pc    = rpc;
            m_fault = 0;
            m_fpc   = 0;
         end else begin
            if (pop) void'(mq.pop_front());
            if (!m_fault) begin
               if (m_bad(m_pc)) begin
                  m_fault = 1;
                  m_fpc   = m_pc;
               end else if (mq.size() < DEPTH) begin
                  e.pc    = m_pc;
                  e.instr = 32'hA000_0000 + m_pc / 4;
                  mq.push_back(e);
                  m_pc = m_pc + 4;
               end
            end
         end
      end
   endtask

   function automatic logic [31:0] pick_target();
      case ($urandom_range(0, 4))
         0, 1:    return 32'($urandom_range(0, MEM_BYTES / 4 - 1)) * 4;
         2:       return 32'(MEM_BYTES) - 4 * 32'($urandom_range(1, 3));
         3:       return (32'($urandom_range(0, MEM_BYTES - 1)) & ~32'h3) | 32'($urandom_range(1, 3));
         default: return ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : 32'(MEM_BYTES) + 32'($urandom_range(0, 15)) * 4;
      endcase
   endfunction

   initial begin
      logic        r_rst;
      logic        r_rv;
      logic [31:0] r_rpc;
      logic        r_rdy;

      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;

      //                 rst rv rpc           rdy  v  pc      instr          f  fpc           addr
      add(1, 0, 32'h0,        1, 0, 32'h0,   32'h0,         0, 32'h0,        32'h0);
      add(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,         0, 32'h0,        32'h0);
      add(0, 0, 32'h0,        1, 1, 32'h0,   32'hA000_0000, 0, 32'h0,        32'h4);
      add(0, 0, 32'h0,        1, 1, 32'h4,   32'hA000_0001, 0, 32'h0,        32'h8);
      add(0, 0, 32'h0,        1, 1, 32'h8,   32'hA000_0002, 0, 32'h0,        32'hC);
      add(1, 0, 32'h0,        0, 1, 32'hC,   32'hA000_0003, 0, 32'h0,        32'h10);
      add(0, 0, 32'h0,        0, 0, 32'h0,   32'h0,         0, 32'h0,        32'h0);
      add(0, 0, 32'h0,        0, 1, 32'h0,   32'hA000_0000, 0, 32'h0,        32'h4);
      add(0, 0, 32'h0,        0, 1, 32'h0,   32'hA000_0000, 0, 32'h0,        32'h8);
      add(0, 0, 32'h0,        0, 1, 32'h0,   32'hA000_0000, 0, 32'h0,        32'h8);
      add(0, 0, 32'h0,        0, 1, 32'h0,   32'hA000_0000, 0, 32'h0,        32'h8);
      add(0, 0, 32'h0,        1, 1, 32'h0,   32'hA000_0000, 0, 32'h0,        32'h8);
      add(0, 0, 32'h0,        1, 1, 32'h4,   32'hA000_0001, 0, 32'h0,        32'hC);
      add(0, 0, 32'h0,        0, 1, 32'h8,   32'hA000_0002, 0, 32'h0,        32'h10);
      add(0, 1, 32'h100,      0, 1, 32'h8,   32'hA000_0002, 0, 32'h0,        32'h10);
      add(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,         0, 32'h0,        32'h100);
      add(0, 0, 32'h0,        1, 1, 32'h100, 32'hA000_0040, 0, 32'h0,        32'h104);
      add(0, 0, 32'h0,        1, 1, 32'h104, 32'hA000_0041, 0, 32'h0,        32'h108);
      add(0, 1, 32'h3F8,      1, 1, 32'h108, 32'hA000_0042, 0, 32'h0,        32'h10C);
      add(0, 0, 32'h0,        0, 0, 32'h0,   32'h0,         0, 32'h0,        32'h3F8);
      add(0, 0, 32'h0,        0, 1, 32'h3F8, 32'hA000_00FE, 0, 32'h0,        32'h3FC);
      add(0, 0, 32'h0,        0, 1, 32'h3F8, 32'hA000_00FE, 0, 32'h0,        32'h3FC);
      add(0, 0, 32'h0,        1, 1, 32'h3F8, 32'hA000_00FE, 1, 32'h400,      32'h3FC);
      add(0, 0, 32'h0,        1, 1, 32'h3FC, 32'hA000_00FF, 1, 32'h400,      32'h3FC);
      add(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,         1, 32'h400,      32'h3FC);
      add(0, 1, 32'h102,      1, 0, 32'h0,   32'h0,         1, 32'h400,      32'h3FC);
      add(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,         0, 32'h0,        32'h3FC);
      add(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,         1, 32'h102,      32'h3FC);
      add(0, 1, 32'h10,       1, 0, 32'h0,   32'h0,         1, 32'h102,      32'h3FC);
      add(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,         0, 32'h0,        32'h10);
      add(0, 0, 32'h0,        1, 1, 32'h10,  32'hA000_0004, 0, 32'h0,        32'h14);
      add(0, 0, 32'h0,        0, 1, 32'h14,  32'hA000_0005, 0, 32'h0,        32'h18);
      add(0, 0, 32'h0,        0, 1, 32'h14,  32'hA000_0005, 0, 32'h0,        32'h1C);
      add(1, 1, 32'h200,      0, 1, 32'h14,  32'hA000_0005, 0, 32'h0,        32'h1C);
      add(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,         0, 32'h0,        32'h0);
      add(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h0,  32'hA000_0000, 0, 32'h0,        32'h4);
      add(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,         0, 32'h0,        32'h4);
      add(0, 0, 32'h0,        1, 0, 32'h0,   32'h0,         1, 32'hFFFF_FFFC, 32'h4);

      repeat (2) @(posedge clk);
      @(negedge clk);

      foreach (vecs[i]) begin
         reset          = vecs[i].rst;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         out_ready      = vecs[i].rdy;
         #1;
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
         chk($sformatf("vec%0d out_pc", i), out_pc, vecs[i].epc);
         chk($sformatf("vec%0d out_instr", i), out_instr, vecs[i].einstr);
         chk($sformatf("vec%0d fault", i), 32'(fault), 32'(vecs[i].ef));
         chk($sformatf("vec%0d fault_pc", i), fault_pc, vecs[i].efpc);
         chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].eaddr);
`ifdef FETCH_PERF_EN
         if (i == 34) begin
            chk("perf_fetched after reset", perf_fetched, 32'h0);
            chk("perf_stalls after reset", perf_stalls, 32'h0);
            chk("perf_flushes after reset", 32'(perf_flushes), 32'h0);
         end
`endif
         @(posedge clk);
         @(negedge clk);
      end

      // Randomized run; the first cycle is a reset that aligns the model.
      for (int c = 0; c < 3000; c++) begin
         r_rst = (c == 0) || ($urandom_range(0, 199) == 0);
         r_rv  = ($urandom_range(0, 19) == 0);
         r_rpc = r_rv ? pick_target() : 32'($urandom);
         r_rdy = ($urandom_range(0, 9) < 7);
         reset          = r_rst;
         redirect_valid = r_rv;
         redirect_pc    = r_rpc;
         out_ready      = r_rdy;
         #1;
         if (c > 0) begin
            chk("rnd out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("rnd out_pc", out_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
            chk("rnd out_instr", out_instr, (mq.size() > 0) ? mq[0].instr : 32'h0);
            chk("rnd fault", 32'(fault), 32'(m_fault));
            if (m_fault) chk("rnd fault_pc", fault_pc, m_fpc);
            chk("rnd imem_addr", imem_addr, m_addr());
         end
         @(posedge clk);
         m_step(r_rst, r_rv, r_rpc, r_rdy);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
